// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It pulls the clock low to request to send, then shifts
// out start, data, parity and stop bits, checks the device ACK, and times out the frame.
module ps2_host_tx #(
    parameter int CLKS_INHIBIT = 1600,
    parameter int CLKS_TIMEOUT = 240000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_REL,
        S_FINISH
    } state_t;

    localparam int INH_W = $clog2(CLKS_INHIBIT + 1);
    localparam int TO_W  = $clog2(CLKS_TIMEOUT + 1);
    localparam logic [INH_W-1:0] INH_DATA = INH_W'(CLKS_INHIBIT - 2);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(CLKS_INHIBIT - 1);
    // The counter restarts in the cycle after REQ, so this match puts FINISH
    // exactly CLKS_TIMEOUT cycles after REQ.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CLKS_TIMEOUT - 2);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(CLKS_TIMEOUT);

    state_t           r_state;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [3:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_data_s1, r_data_s2;

    logic w_fall;
    logic w_timed;
    logic w_timeout;

    // NOTE: synchroniser flops reset to 1 because an idle open-drain line reads high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data_in;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timed   = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_REL);
    assign w_timeout = w_timed && (r_to_cnt == TO_LAST);

    // NOTE: every output is a register set on the transition into the state that owns it,
    // so each change is scheduled one cycle ahead of where it must be visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_timed && (r_to_cnt != TO_MAX)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_timeout) begin
                // A falling edge in this same cycle is deliberately dropped.
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_busy    <= 1'b0;
                r_error   <= 1'b1;
                r_state   <= S_FINISH;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_start) begin
                            r_shift   <= tx_data;
                            r_parity  <= ~^tx_data;
                            r_bit_cnt <= '0;
                            r_inh_cnt <= '0;
                            r_to_cnt  <= '0;
                            r_clk_oe  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_inh_cnt != INH_LAST) begin
                            r_inh_cnt <= r_inh_cnt + 1'b1;
                        end
                        if (r_inh_cnt == INH_DATA) begin
                            r_data_oe <= 1'b1;
                        end
                        if (r_inh_cnt == INH_LAST) begin
                            r_clk_oe <= 1'b0;
                            r_state  <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        r_to_cnt <= '0;
                        r_state  <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (w_fall) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt < 4'd8) begin
                                r_data_oe <= ~r_shift[r_bit_cnt[2:0]];
                            end else if (r_bit_cnt == 4'd8) begin
                                r_data_oe <= ~r_parity;
                            end else begin
                                r_data_oe <= 1'b0;
                                r_state   <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            if (!r_data_s2) begin
                                r_state <= S_WAIT_REL;
                            end else begin
                                r_busy  <= 1'b0;
                                r_error <= 1'b1;
                                r_state <= S_FINISH;
                            end
                        end
                    end
                    S_WAIT_REL: begin
                        if (r_clk_s2 && r_data_s2) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx. A behavioural keyboard drives the open-drain lines, and expected
// frames and outcomes are queued at each tx_start and compared when the transfer ends.
module tb_ps2_host_tx;

    localparam int INH = 1600;
    localparam int TMO = 10000;
    localparam int H   = 200;   // keyboard clock half period, in clk cycles

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic       dev_clk_low;
    logic       dev_data_low;

    int n_checks;
    int n_errors;
    int cyc, n_done, n_err, n_both, n_busy_pulse;
    int inh_run, inh_data_run, inh_len, inh_data, req_cyc, err_cyc;
    logic       req_data_oe, prev_clk_oe, done_lines_hi;
    logic [1:0] err_oe;
    logic [10:0] last_frame;

    typedef struct packed {
        logic [10:0] frame;
        logic        exp_done;
    } exp_t;

    exp_t sb_q[$];

    ps2_host_tx #(
        .CLKS_INHIBIT(INH),
        .CLKS_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            inh_run      <= 0;
            inh_data_run <= 0;
            prev_clk_oe  <= 1'b0;
        end else begin
            if (done) begin
                n_done        <= n_done + 1;
                done_lines_hi <= ps2_clk_in & ps2_data_in;
            end
            if (error) begin
                n_err   <= n_err + 1;
                err_cyc <= cyc;
                err_oe  <= {ps2_clk_oe, ps2_data_oe};
            end
            if (done && error) n_both <= n_both + 1;
            if ((done || error) && busy) n_busy_pulse <= n_busy_pulse + 1;
            if (ps2_clk_oe) begin
                inh_run <= inh_run + 1;
                if (ps2_data_oe) inh_data_run <= inh_data_run + 1;
            end else if (prev_clk_oe) begin
                inh_len      <= inh_run;
                inh_data     <= inh_data_run;
                req_cyc      <= cyc;
                req_data_oe  <= ps2_data_oe;
                inh_run      <= 0;
                inh_data_run <= 0;
            end
            prev_clk_oe <= ps2_clk_oe;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic start_tx(input string tag, input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_after_start got %b exp 1", tag, busy);
        end
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1 && busy === 1'b1) && n < INH + 500) begin
            @(negedge clk);
            n++;
        end
        ok = (n < INH + 500);
    endtask

    task automatic dev_cycle(input bit pull_data, output logic smp);
        repeat (H / 2) @(negedge clk);
        if (pull_data) dev_data_low = 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        smp = ps2_data_in;
    endtask

    task automatic device_xfer(input bit ack_low, output logic [10:0] fr, output bit ok);
        logic smp;
        fr = '0;
        wait_req(ok);
        if (!ok) return;
        repeat (20) @(negedge clk);
        fr[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            dev_cycle(ack_low && (k == 11), smp);
            if (k <= 10) fr[k] = smp;
        end
        repeat (H / 2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] d, input logic par,
                            input bit ack_low, input bit inject);
        exp_t        ex;
        logic [10:0] fr;
        bit          ok;
        int          d0, e0;
        ex.frame    = {1'b1, par, d, 1'b0};
        ex.exp_done = ack_low;
        sb_q.push_back(ex);
        d0 = n_done;
        e0 = n_err;
        start_tx(tag, d);
        fork
            device_xfer(ack_low, fr, ok);
            if (inject) begin
                repeat (2900) @(negedge clk);
                n_checks++;
                if (busy !== 1'b1 || ps2_clk_oe !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s in_shift busy=%b clk_oe=%b exp 1/0", tag, busy, ps2_clk_oe);
                end
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        ex = sb_q.pop_front();
        last_frame = fr;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s request never seen", tag);
        end
        n_checks++;
        if (fr !== ex.frame) begin
            n_errors++;
            $display("FAIL %s frame got %b exp %b", tag, fr, ex.frame);
        end
        n_checks++;
        if ((n_done - d0) !== int'(ex.exp_done)) begin
            n_errors++;
            $display("FAIL %s done_pulses got %0d exp %0d", tag, n_done - d0, ex.exp_done);
        end
        n_checks++;
        if ((n_err - e0) !== int'(!ex.exp_done)) begin
            n_errors++;
            $display("FAIL %s error_pulses got %0d exp %0d", tag, n_err - e0, !ex.exp_done);
        end
        n_checks++;
        if (inh_len !== INH) begin
            n_errors++;
            $display("FAIL %s inhibit_len got %0d exp %0d", tag, inh_len, INH);
        end
        n_checks++;
        if (inh_data !== 1 || req_data_oe !== 1'b1) begin
            n_errors++;
            $display("FAIL %s start_bit inh_data=%0d req_data_oe=%b exp 1/1", tag, inh_data, req_data_oe);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s busy_at_end got %b exp 0", tag, busy);
        end
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, error} !== 5'b00000) begin
            n_errors++;
            $display("FAIL reset outputs got %b exp 00000", {ps2_clk_oe, ps2_data_oe, busy, done, error});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle outputs got %b exp 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
    endtask

    task automatic test_send_ed;
        run_xfer("ed", 8'hED, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (last_frame !== 11'b11111011010) begin
            n_errors++;
            $display("FAIL ed line_sequence got %b exp 11111011010", last_frame);
        end
    endtask

    task automatic test_parity_f4;
        run_xfer("f4", 8'hF4, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (last_frame[9] !== 1'b0) begin
            n_errors++;
            $display("FAIL f4 parity_bit got %b exp 0", last_frame[9]);
        end
        n_checks++;
        if (done_lines_hi !== 1'b1) begin
            n_errors++;
            $display("FAIL f4 lines_at_done got %b exp 1", done_lines_hi);
        end
    endtask

    task automatic test_timeout;
        int d0, e0, n;
        d0 = n_done;
        e0 = n_err;
        start_tx("timeout", 8'hED);
        n = 0;
        while (n_err == e0 && n < INH + TMO + 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ((n_err - e0) !== 1) begin
            n_errors++;
            $display("FAIL timeout error_pulses got %0d exp 1", n_err - e0);
        end
        n_checks++;
        if ((err_cyc - req_cyc) !== TMO) begin
            n_errors++;
            $display("FAIL timeout latency got %0d exp %0d", err_cyc - req_cyc, TMO);
        end
        n_checks++;
        if (err_oe !== 2'b00 || n_done !== d0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout oe=%b done_delta=%0d busy=%b exp 00/0/0", err_oe, n_done - d0, busy);
        end
    endtask

    task automatic test_nack;
        run_xfer("nack", 8'hA5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored;
        int d0;
        run_xfer("ignore", 8'h3C, 1'b1, 1'b1, 1'b1);
        d0 = n_done;
        repeat (100) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || n_done !== d0) begin
            n_errors++;
            $display("FAIL ignore restarted busy=%b clk_oe=%b exp 0/0", busy, ps2_clk_oe);
        end
    endtask

    task automatic test_reset_mid;
        int   d0, e0;
        bit   ok;
        logic smp;
        d0 = n_done;
        e0 = n_err;
        start_tx("rstmid", 8'h00);
        wait_req(ok);
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++) dev_cycle(1'b0, smp);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!ok || ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid before_reset ok=%b data_oe=%b busy=%b exp 1/1/1", ok, ps2_data_oe, busy);
        end
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL rstmid async_clear got %b exp 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++;
        if (n_done !== d0 || n_err !== e0) begin
            n_errors++;
            $display("FAIL rstmid pulses done=%0d error=%0d exp 0/0", n_done - d0, n_err - e0);
        end
        run_xfer("rstmid_ed", 8'hED, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_pulse_rules;
        n_checks++;
        if (n_both !== 0 || n_busy_pulse !== 0) begin
            n_errors++;
            $display("FAIL pulse_rules both=%0d busy_high=%0d exp 0/0", n_both, n_busy_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity_f4();
        test_timeout();
        test_nack();
        test_start_ignored();
        test_reset_mid();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
